// File: rtl/mux21_arb.sv
// -----------------------------------------------------------------------------
// mux21_arb
//   Two-requester round-robin arbiter that produces the SEL input of the
//   downstream mux21 2:1 selector. Each owner keeps the path for a bounded
//   burst of BURST_LEN cycles while the other side is also requesting, then
//   ownership moves across with no idle bubble. All outputs are registered,
//   so SEL makes exactly one transition per handover.
//
// Parameters
//   BURST_LEN  : max consecutive owned cycles under contention (1..255)
//   SW_CNT_W   : width of the handover counter SW_CNT
//
// Ports
//   CLK         in   rising-edge clock
//   RST_N       in   asynchronous active-low reset
//   REQ_A       in   source A requests the mux path
//   REQ_B       in   source B requests the mux path
//   LOCK        in   owner holds the grant past burst expiry (optional)
//   GNT_A       out  A owns the path this cycle
//   GNT_B       out  B owns the path this cycle
//   SEL         out  mux21 select: 0 routes A to Z, 1 routes B to Z
//   VALID       out  a source is granted (GNT_A | GNT_B)
//   SW_CNT      out  count of direct A<->B handovers, wraps to 0
//   o_dbg_state out  current FSM state (IDLE=00, OWN_A=01, OWN_B=10)
//
// Optional feature
//   MUX21_ARB_LOCK_EN : when defined, adds the LOCK input. While the owner
//   holds LOCK=1 burst expiry is ignored and the burst counter saturates.
//   Dropping the owner's REQ still releases the grant. Undefined: pure
//   round-robin, no LOCK port.
//
// Handshake: REQ_x is a level request sampled at every rising edge; the
//   matching GNT_x rises after the edge that sampled it (1-cycle latency)
//   and stays high for as long as that side owns the path. There is no
//   back-pressure on the grant side.
// -----------------------------------------------------------------------------
module mux21_arb #(
  parameter int BURST_LEN = 4,
  parameter int SW_CNT_W  = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                REQ_A,
  input  logic                REQ_B,
`ifdef MUX21_ARB_LOCK_EN
  input  logic                LOCK,
`endif
  output logic                GNT_A,
  output logic                GNT_B,
  output logic                SEL,
  output logic                VALID,
  output logic [SW_CNT_W-1:0] SW_CNT,
  output logic [1:0]          o_dbg_state
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  // One bit per owner so each grant output is a flop output, not a decode.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_A = 2'b01;
  localparam logic [1:0] OWN_B = 2'b10;

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_last_b;   // 1: B was served last, so A wins a tie
  logic                r_sel;
  logic                r_valid;
  logic [SW_CNT_W-1:0] r_sw_cnt;

  logic [1:0]          w_nxt_state;
  logic [CNT_W-1:0]    w_nxt_cnt;
  logic                w_own_req;
  logic                w_oth_req;
  logic [1:0]          w_oth_state;
  logic                w_lock;
  logic                w_direct;

`ifdef MUX21_ARB_LOCK_EN
  assign w_lock = LOCK;
`else
  assign w_lock = 1'b0;
`endif

  assign w_own_req   = (r_state == OWN_B) ? REQ_B : REQ_A;
  assign w_oth_req   = (r_state == OWN_B) ? REQ_A : REQ_B;
  assign w_oth_state = (r_state == OWN_B) ? OWN_A : OWN_B;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_nxt_cnt = '0;
        if (REQ_A && REQ_B) begin
          w_nxt_state = r_last_b ? OWN_A : OWN_B;
        end else if (REQ_A) begin
          w_nxt_state = OWN_A;
        end else if (REQ_B) begin
          w_nxt_state = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (!w_own_req) begin
          // Release wins over everything, including an expiring burst.
          w_nxt_cnt   = '0;
          w_nxt_state = w_oth_req ? w_oth_state : IDLE;
        end else if (r_cnt == CNT_MAX) begin
          if (w_lock) begin
            w_nxt_cnt = r_cnt;  // saturate while locked
          end else begin
            // Burst expired: hand over if contended, else restart the burst.
            w_nxt_cnt = '0;
            if (w_oth_req) begin
              w_nxt_state = w_oth_state;
            end
          end
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Only owner-to-owner moves count; anything passing through IDLE does not.
  assign w_direct = (r_state != IDLE) && (w_nxt_state != IDLE) &&
                    (w_nxt_state != r_state);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last_b <= 1'b1;
      r_sel    <= 1'b0;
      r_valid  <= 1'b0;
      r_sw_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_valid <= (w_nxt_state != IDLE);
      // SEL only moves when an owner is (re)entered, so it holds in IDLE.
      if (w_nxt_state == OWN_A) begin
        r_sel    <= 1'b0;
        r_last_b <= 1'b0;
      end else if (w_nxt_state == OWN_B) begin
        r_sel    <= 1'b1;
        r_last_b <= 1'b1;
      end
      if (w_direct) begin
        r_sw_cnt <= r_sw_cnt + 1'b1;
      end
    end
  end

  assign GNT_A       = r_state[0];
  assign GNT_B       = r_state[1];
  assign SEL         = r_sel;
  assign VALID       = r_valid;
  assign SW_CNT      = r_sw_cnt;
  assign o_dbg_state = r_state;

  a_burst_len_range: assert property (@(posedge CLK)
    (BURST_LEN >= 1) && (BURST_LEN <= 255))
    else $error("mux21_arb: BURST_LEN %0d outside 1..255", BURST_LEN);

  a_gnt_exclusive: assert property (@(posedge CLK) disable iff (!RST_N)
    !(GNT_A && GNT_B))
    else $error("mux21_arb: GNT_A and GNT_B both high");

endmodule

// File: tb/tb_mux21_arb.sv
module tb_mux21_arb;

  localparam int BURST_LEN = 4;
  localparam int SW_CNT_W  = 8;
  localparam int EW        = 4 + SW_CNT_W;  // {gnt_a, gnt_b, sel, valid, sw_cnt}

  // ---------------------------------------------------------------- clock/reset
  logic                CLK = 1'b0;
  logic                RST_N;
  logic                REQ_A;
  logic                REQ_B;
`ifdef MUX21_ARB_LOCK_EN
  logic                LOCK;
`endif
  logic                GNT_A;
  logic                GNT_B;
  logic                SEL;
  logic                VALID;
  logic [SW_CNT_W-1:0] SW_CNT;
  logic [1:0]          dbg_state;

  always #5 CLK = ~CLK;

  mux21_arb #(.BURST_LEN(BURST_LEN), .SW_CNT_W(SW_CNT_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ_A      (REQ_A),
    .REQ_B      (REQ_B),
`ifdef MUX21_ARB_LOCK_EN
    .LOCK       (LOCK),
`endif
    .GNT_A      (GNT_A),
    .GNT_B      (GNT_B),
    .SEL        (SEL),
    .VALID      (VALID),
    .SW_CNT     (SW_CNT),
    .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          a;
    logic          b;
    logic [EW-1:0] e;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [EW-1:0] pack(input logic ga, input logic gb,
                                         input logic sel, input logic v,
                                         input int sw);
    return {ga, gb, sel, v, SW_CNT_W'(sw)};
  endfunction

  function automatic void add(input logic a, input logic b, input logic ga,
                              input logic gb, input logic sel, input logic v,
                              input int sw);
    vec_t t;
    t.a = a;
    t.b = b;
    t.e = pack(ga, gb, sel, v, sw);
    vecs.push_back(t);
  endfunction

  task automatic check_val(input string name, input logic [EW-1:0] e);
    logic [EW-1:0] got;
    got = {GNT_A, GNT_B, SEL, VALID, SW_CNT};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got gnt_a=%b gnt_b=%b sel=%b valid=%b sw=%0d, want gnt_a=%b gnt_b=%b sel=%b valid=%b sw=%0d",
               name, got[EW-1], got[EW-2], got[EW-3], got[EW-4], got[SW_CNT_W-1:0],
               e[EW-1], e[EW-2], e[EW-3], e[EW-4], e[SW_CNT_W-1:0]);
    end
  endtask

  task automatic compare_pop(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expected queue empty", name);
    end else begin
      check_val(name, exp_q.pop_front());
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Inputs change 1 time unit after an edge; outputs are sampled at the same
  // point after the following edge.
  task automatic drive(input logic a, input logic b, input logic [EW-1:0] e,
                       input string name);
    REQ_A = a;
    REQ_B = b;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    compare_pop(name);
  endtask

  // ---------------------------------------------------------------- reference model
  int                  m_state;   // 0 idle, 1 A owns, 2 B owns
  int                  m_cnt;
  logic                m_last_b;
  logic                m_sel;
  logic [SW_CNT_W-1:0] m_sw;

  function automatic void model_reset();
    m_state  = 0;
    m_cnt    = 0;
    m_last_b = 1'b1;
    m_sel    = 1'b0;
    m_sw     = '0;
  endfunction

  function automatic logic [EW-1:0] model_step(input logic a, input logic b);
    int   nxt;
    logic own;
    logic oth;
    nxt = m_state;
    if (m_state == 0) begin
      m_cnt = 0;
      if (a && b)  nxt = m_last_b ? 1 : 2;
      else if (a)  nxt = 1;
      else if (b)  nxt = 2;
    end else begin
      own = (m_state == 1) ? a : b;
      oth = (m_state == 1) ? b : a;
      if (!own) begin
        m_cnt = 0;
        nxt   = oth ? 3 - m_state : 0;
      end else if (m_cnt == BURST_LEN - 1) begin
        m_cnt = 0;
        if (oth) nxt = 3 - m_state;
      end else begin
        m_cnt++;
      end
    end
    if (m_state != 0 && nxt != 0 && nxt != m_state) m_sw = m_sw + 1'b1;
    if (nxt == 1) begin m_sel = 1'b0; m_last_b = 1'b0; end
    if (nxt == 2) begin m_sel = 1'b1; m_last_b = 1'b1; end
    m_state = nxt;
    return {nxt == 1, nxt == 2, m_sel, nxt != 0, m_sw};
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [EW-1:0] e;
    logic          ra;
    logic          rb;

    // a  b  ga gb sel v  sw
    add(1, 0, 1, 0, 0, 1, 0);                                   // first grant A
    repeat (3) add(1, 1, 1, 0, 0, 1, 0);                        // A burst 4 cycles
    repeat (4) add(1, 1, 0, 1, 1, 1, 1);                        // B burst
    repeat (4) add(1, 1, 1, 0, 0, 1, 2);                        // A burst
    repeat (2) add(1, 1, 0, 1, 1, 1, 3);                        // B, cnt 0..1
    add(1, 0, 1, 0, 0, 1, 4);                                   // B drops, A waiting
    add(1, 0, 1, 0, 0, 1, 4);                                   // A cnt=1
    add(0, 0, 0, 0, 0, 0, 4);                                   // A drops -> IDLE
    add(0, 1, 0, 1, 1, 1, 4);                                   // via IDLE, no count
    repeat (2) add(0, 0, 0, 0, 1, 0, 4);                        // SEL holds in IDLE
    add(1, 1, 1, 0, 0, 1, 4);                                   // tie, B last -> A
    add(0, 0, 0, 0, 0, 0, 4);
    add(1, 1, 0, 1, 1, 1, 4);                                   // tie, A last -> B
    add(0, 0, 0, 0, 1, 0, 4);
    repeat (5) add(1, 0, 1, 0, 0, 1, 4);                        // lone A, burst restarts
    repeat (3) add(1, 1, 1, 0, 0, 1, 4);                        // restarted count 1..3
    repeat (4) add(1, 1, 0, 1, 1, 1, 5);                        // handover to B
    add(1, 0, 1, 0, 0, 1, 6);                                   // B drops at cnt max
    repeat (3) add(1, 0, 1, 0, 0, 1, 6);
    add(0, 0, 0, 0, 0, 0, 6);                                   // A drops at cnt max

    RST_N = 1'b0;
    REQ_A = 1'b0;
    REQ_B = 1'b0;
`ifdef MUX21_ARB_LOCK_EN
    LOCK  = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    check_val("reset_state", '0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_val("idle_after_release", '0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a B burst.
    drive(0, 1, pack(0, 1, 1, 1, 6), "pre_rst_b0");
    drive(0, 1, pack(0, 1, 1, 1, 6), "pre_rst_b1");
    #2;
    RST_N = 1'b0;
    #1;
    check_val("async_rst_no_edge", '0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_reset();
    e = model_step(1, 1);
    drive(1, 1, pack(1, 0, 0, 1, 0), "post_rst_tie_a");

    // Sustained contention long enough to wrap SW_CNT.
    for (int i = 0; i < 1100; i++) begin
      e = model_step(1, 1);
      drive(1, 1, e, $sformatf("wrap%0d", i));
    end

    // Random request patterns.
    for (int i = 0; i < 1500; i++) begin
      ra = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 3) != 0);
      e  = model_step(ra, rb);
      drive(ra, rb, e, $sformatf("rand%0d", i));
    end

`ifdef MUX21_ARB_LOCK_EN
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    drive(1, 0, pack(1, 0, 0, 1, 0), "lock_own_a");
    LOCK = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, pack(1, 0, 0, 1, 0), $sformatf("lock_hold%0d", i));
    end
    LOCK = 1'b0;
    drive(1, 1, pack(0, 1, 1, 1, 1), "lock_release");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
